// File: rtl/apb_pkg.sv
// Shared state encoding and default widths for the APB master arbiter.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_W = 9;
    localparam int APB_DATA_W = 32;

    // The address MSB chooses between slave 1 (0) and slave 2 (1).
    function automatic int sel_bit(input int addr_w);
        return addr_w - 1;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant logic; ptr names the requester granted last.
module apb_rr_arbiter (
    input  logic [1:0] req_valid,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic pri;

    assign pri = ~ptr;

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = 1'b0;
        if (en) begin
            if (req_valid[pri]) begin
                grant_idx  = pri;
                grant[pri] = 1'b1;
            end else if (req_valid[ptr]) begin
                grant_idx  = ptr;
                grant[ptr] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between two requesters: round-robin grant,
// IDLE/SETUP/ACCESS sequencing, slave decode and a PREADY wait-state timeout.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL1,
    output logic                      PSEL2,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int SEL   = sel_bit(ADDR_W);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic               pwrite_q, pwrite_d;
    logic               grant_q, grant_d;
    logic               ptr_q, ptr_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic               arb_en;
    logic [NUM_REQ-1:0] arb_grant;
    logic               arb_idx;

    assign arb_en = (state_q == ST_IDLE);

    apb_rr_arbiter u_arb (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .en        (arb_en),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_d  = arb_idx;
                    paddr_d  = arb_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                    pwdata_d = arb_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    pwrite_d = req_write[arb_idx];
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_rdata_d          = pwrite_q ? '0 : PRDATA;
                    rsp_err_d            = PSLVERR;
                    ptr_d                = grant_q;
                    wait_cnt_d           = '0;
                    state_d              = ST_IDLE;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This cycle is the last PREADY-low cycle tolerated: abort.
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_rdata_d          = '0;
                    rsp_err_d            = 1'b1;
                    ptr_d                = grant_q;
                    wait_cnt_d           = '0;
                    state_d              = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            grant_q     <= 1'b0;
            ptr_q       <= 1'b1;
            wait_cnt_q  <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Accept is combinational, so it is held off while reset is applied.
    assign req_ready = PRESET ? '0 : arb_grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL1     = (state_q != ST_IDLE) && !paddr_q[SEL];
    assign PSEL2     = (state_q != ST_IDLE) &&  paddr_q[SEL];
    assign PENABLE   = (state_q == ST_ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench: directed vector table, reset and contention sequences,
// then randomized traffic against a transaction-level reference model.
module tb_apb_master_arbiter;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                PCLK = 1'b0;
    logic                PRESET;
    logic [1:0]          req_valid, req_write, req_ready, rsp_valid;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]   rsp_rdata, PWDATA, PRDATA;
    logic                rsp_err, PSEL1, PSEL2, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [ADDR_W-1:0]   PADDR;

    always #5 PCLK = ~PCLK;

    apb_master_arbiter #(.NUM_REQ(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    int checks = 0;
    int errors = 0;

    // Requester-side model: pending requests and their payloads.
    logic [1:0]        pend;
    logic              pwr   [2];
    logic [ADDR_W-1:0] paddr [2];
    logic [DATA_W-1:0] pwd   [2];
    int                last_g;

    // Response expected in the cycle after a transfer completes.
    bit                rsp_pend;
    int                rsp_g;
    logic [DATA_W-1:0] rsp_rd;
    logic              rsp_er;

    typedef struct {
        int                req;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                waits;
        logic [DATA_W-1:0] prdata;
        logic              slverr;
        logic              exp_sel2;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < 2; k++) begin
            req_valid[k]                    = pend[k];
            req_write[k]                    = pwr[k];
            req_addr[k*ADDR_W +: ADDR_W]    = paddr[k];
            req_wdata[k*DATA_W +: DATA_W]   = pwd[k];
        end
    endtask

    task automatic new_req(input int k);
        pend[k]  = 1'b1;
        pwr[k]   = 1'($urandom_range(0, 1));
        paddr[k] = ADDR_W'($urandom);
        pwd[k]   = $urandom;
    endtask

    // Idle/response cycle: checks the pending response and the accept (g < 0: none).
    task automatic check_accept(input int g);
        logic [1:0] exp_rdy;
        logic [1:0] exp_rv;
        exp_rdy = (g < 0) ? 2'b00 : (2'b01 << g);
        @(negedge PCLK);
        if (rsp_pend) begin
            exp_rv = 2'b01 << rsp_g;
            check("rsp_valid", rsp_valid, exp_rv);
            check("rsp_rdata", rsp_rdata, rsp_rd);
            check("rsp_err", rsp_err, rsp_er);
        end else begin
            check("rsp_valid_quiet", rsp_valid, 2'b00);
        end
        check("bus_idle", {PSEL1, PSEL2, PENABLE}, 3'b000);
        check("req_ready", req_ready, exp_rdy);
        rsp_pend = 1'b0;
    endtask

    // One complete transfer starting in an IDLE cycle whose request inputs are already driven.
    task automatic do_xfer(input int g, input int waits, input logic [DATA_W-1:0] prdata,
                           input logic slverr, input logic exp_sel2,
                           input logic [DATA_W-1:0] exp_rdata, input logic exp_err);
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic              rdy;
        int                n_acc;
        wr    = pwr[g];
        addr  = paddr[g];
        wd    = pwd[g];
        n_acc = (waits >= TIMEOUT) ? TIMEOUT : waits + 1;
        check_accept(g);
        @(posedge PCLK); #1;
        pend[g]      = 1'b0;
        req_valid[g] = 1'b0;
        @(negedge PCLK);
        check("setup_bus", {PSEL1, PSEL2, PENABLE}, {~exp_sel2, exp_sel2, 1'b0});
        check("setup_paddr", PADDR, addr);
        check("setup_pwrite", PWRITE, wr);
        check("setup_pwdata", PWDATA, wd);
        check("busy_ready", req_ready, 2'b00);
        for (int i = 0; i < n_acc; i++) begin
            @(posedge PCLK); #1;
            rdy     = (i == waits) && (waits < TIMEOUT);
            PREADY  = rdy;
            PRDATA  = rdy ? prdata : $urandom;
            PSLVERR = rdy ? slverr : 1'b1;
            @(negedge PCLK);
            check("access_bus", {PSEL1, PSEL2, PENABLE}, {~exp_sel2, exp_sel2, 1'b1});
            if (i == n_acc - 1) begin
                check("access_paddr", PADDR, addr);
                check("access_pwdata", PWDATA, wd);
                check("access_rsp_quiet", rsp_valid, 2'b00);
            end
        end
        @(posedge PCLK); #1;
        PREADY   = 1'b0;
        PSLVERR  = 1'b0;
        PRDATA   = $urandom;
        rsp_pend = 1'b1;
        rsp_g    = g;
        rsp_rd   = exp_rdata;
        rsp_er   = exp_err;
        last_g   = g;
    endtask

    initial begin
        int                g, pri, waits;
        bit                to;
        logic [DATA_W-1:0] prd;
        logic              serr;

        vecs[0] = '{0, 1'b1, 9'h005, 32'h000000A5, 0,  32'h00001234, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[1] = '{1, 1'b0, 9'h103, 32'h11111111, 2,  32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{0, 1'b1, 9'h010, 32'h22222222, 0,  32'h33333333, 1'b1, 1'b0, 32'h0,        1'b1};
        vecs[3] = '{1, 1'b1, 9'h010, 32'h44444444, 0,  32'h55555555, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[4] = '{0, 1'b0, 9'h1FF, 32'h66666666, 16, 32'h77777777, 1'b0, 1'b1, 32'h0,        1'b1};
        vecs[5] = '{1, 1'b0, 9'h0AA, 32'h88888888, 15, 32'h00000055, 1'b0, 1'b0, 32'h00000055, 1'b0};
        vecs[6] = '{0, 1'b0, 9'h100, 32'h99999999, 1,  32'h0BADF00D, 1'b1, 1'b1, 32'h0BADF00D, 1'b1};

        // Reset with both requesters already asserting.
        PRESET  = 1'b1;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        pend    = '0;
        new_req(0);
        new_req(1);
        drive_reqs();
        rsp_pend = 1'b0;
        last_g   = 1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_bus", {PSEL1, PSEL2, PENABLE, PWRITE}, 4'b0000);
        check("rst_paddr", PADDR, 9'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Contention: both hold their requests, grants must alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            g   = i % 2;
            prd = $urandom;
            do_xfer(g, 0, prd, 1'b0, paddr[g][ADDR_W-1], pwr[g] ? 32'h0 : prd, 1'b0);
            new_req(g);
            drive_reqs();
        end

        // Directed vectors, one requester at a time.
        foreach (vecs[v]) begin
            pend            = '0;
            g               = vecs[v].req;
            pend[g]         = 1'b1;
            pwr[g]          = vecs[v].wr;
            paddr[g]        = vecs[v].addr;
            pwd[g]          = vecs[v].wdata;
            paddr[1 - g]    = ADDR_W'($urandom);
            pwd[1 - g]      = $urandom;
            drive_reqs();
            do_xfer(g, vecs[v].waits, vecs[v].prdata, vecs[v].slverr,
                    vecs[v].exp_sel2, vecs[v].exp_rdata, vecs[v].exp_err);
        end

        // Reset during an ACCESS wait state: requester 1 owns the bus (0 was last).
        new_req(0);
        new_req(1);
        pwr[1]   = 1'b0;
        paddr[1] = 9'h1F0;
        drive_reqs();
        check_accept(1);
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("pre_rst_access", {PSEL1, PSEL2, PENABLE}, 3'b011);
        @(posedge PCLK); #3;
        PRESET = 1'b1;
        #1;
        check("midrst_bus", {PSEL1, PSEL2, PENABLE, PWRITE}, 4'b0000);
        check("midrst_paddr", PADDR, 9'h0);
        check("midrst_pwdata", PWDATA, 32'h0);
        check("midrst_rsp", {rsp_valid, rsp_err}, 3'b000);
        check("midrst_rdata", rsp_rdata, 32'h0);
        check("midrst_ready", req_ready, 2'b00);
        repeat (2) begin
            @(negedge PCLK);
            check("midrst_no_rsp", rsp_valid, 2'b00);
        end
        @(posedge PCLK); #1;
        PRESET   = 1'b0;
        rsp_pend = 1'b0;
        last_g   = 1;
        prd      = $urandom;
        do_xfer(0, 0, prd, 1'b0, paddr[0][ADDR_W-1], pwr[0] ? 32'h0 : prd, 1'b0);

        // Randomized traffic against the round-robin transaction model.
        for (int t = 0; t < 150; t++) begin
            for (int k = 0; k < 2; k++)
                if (!pend[k] && $urandom_range(0, 2) != 0) new_req(k);
            if (pend == 2'b00) new_req(int'($urandom_range(0, 1)));
            drive_reqs();
            pri   = (last_g + 1) % 2;
            g     = pend[pri] ? pri : 1 - pri;
            waits = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 4))
                                                : int'($urandom_range(0, 3));
            to    = (waits >= TIMEOUT);
            prd   = $urandom;
            serr  = ($urandom_range(0, 3) == 0);
            do_xfer(g, waits, prd, serr, paddr[g][ADDR_W-1],
                    (pwr[g] || to) ? 32'h0 : prd, to || serr);
        end

        pend = '0;
        drive_reqs();
        check_accept(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ requesters, for example the GPIO-side and UART-side controllers.
- Arbitrates between requesters round-robin and sequences the IDLE/SETUP/ACCESS protocol.
- Decodes the address MSB into PSEL1/PSEL2, supports PREADY wait states and PSLVERR, and enforces a wait-state timeout.
- Returns read data and error status to the requester that was granted.

Parameters:
- NUM_REQ, 2, number of requesters; the design supports exactly 2, and other values are out of scope.
- ADDR_W, 9, width of request and APB addresses; bit ADDR_W-1 selects the slave.
- DATA_W, 32, data width.
- TIMEOUT, 16, maximum PREADY-low cycles allowed in ACCESS before the transfer is aborted.

Ports:
- PCLK  in  1  clock; all logic is on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_write  in  NUM_REQ  1 = write, 0 = read, per requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester k uses slice k.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  DATA_W  read data, valid while rsp_valid is high.
- rsp_err  out  1  PSLVERR or timeout, valid while rsp_valid is high.
- PSEL1  out  1  select for slave 1 (PADDR[ADDR_W-1]=0).
- PSEL2  out  1  select for slave 2 (PADDR[ADDR_W-1]=1).
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (asynchronous, PRESET=1):
  - State goes to IDLE.
  - All outputs go to 0: req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL1/2, PENABLE, PWRITE, PADDR, PWDATA.
  - Round-robin pointer resets so that requester 0 has priority.
  - Wait counter goes to 0.
- Reset mid-transfer: the transfer is dropped silently, with no rsp_valid. Requesters re-issue the transfer after reset.
- State machine has three states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is high, grant one requester g.
  - Priority goes to the requester after the last granted one; if that requester has no request, the other is granted.
  - req_ready[g] is high for this single cycle, combinational from IDLE and req_valid.
  - On the same edge, latch PADDR, PWDATA and PWRITE from slice g and record g.
  - Next state is SETUP.
  - If no request is pending, stay in IDLE.
- SETUP:
  - PSELx is high according to PADDR[ADDR_W-1]; PENABLE is 0.
  - Next state is ACCESS unconditionally.
- ACCESS:
  - PSELx and PENABLE are both high.
  - If PREADY=1:
    - Capture PRDATA into rsp_rdata (reads only; writes return 0).
    - Capture PSLVERR into rsp_err.
    - Pulse rsp_valid[g] in the next cycle.
    - Deassert PSEL and PENABLE; next state is IDLE.
    - Update the round-robin pointer to g.
  - If PREADY=0, increment the wait counter.
  - Timeout: when the counter reaches TIMEOUT with PREADY still 0:
    - Abort and deassert PSEL and PENABLE.
    - Pulse rsp_valid[g] with rsp_err=1 and rsp_rdata=0.
    - Next state is IDLE; the pointer is updated.
    - The counter clears on every exit from ACCESS.
- Latency with zero wait states:
  - Cycle 0 accept, cycle 1 SETUP, cycle 2 ACCESS, cycle 3 rsp_valid with state IDLE.
  - A new accept can occur in cycle 3, so throughput is one transfer per 3 cycles.
  - Each wait state adds one cycle.
- Stability: PADDR, PWRITE and PWDATA hold from SETUP through the end of ACCESS and keep their last value in IDLE. req_* inputs are ignored outside IDLE.
- Simultaneous requests: exactly one req_ready bit is ever high; the loser keeps req_valid high and is granted next.
- PSEL1 and PSEL2 are never high together.
- PSLVERR is sampled only in the ACCESS cycle where PREADY=1.

Decomposition:
- Shared package apb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SETUP=2'd1, ST_ACCESS=2'd2;
  - default widths ADDR_W=9, DATA_W=32;
  - slave-select bit index.
- One sub-module is natural: apb_rr_arbiter. It takes req_valid, the pointer and an enable, and produces a one-hot grant plus the index. It is purely combinational; the pointer register lives in the top level.

Test Plan:
- Single write: req0 addr 9'h005, wdata 32'hA5, PREADY tied 1 → req_ready[0] in cycle 0, PSEL1=1/PENABLE=0 in cycle 1, PENABLE=1 in cycle 2, rsp_valid[0]=1 with rsp_err=0 in cycle 3.
- Read from slave 2: req1 read addr 9'h103, PRDATA=32'hDEADBEEF, PREADY low for 2 ACCESS cycles → PSEL2 only, ACCESS lasts 3 cycles, rsp_rdata=32'hDEADBEEF.
- Contention: both requesters assert from reset and hold → grants in the order 0, 1, 0, 1; no overlapping req_ready.
- Slave error: PSLVERR=1 with PREADY=1 on a write to 9'h010 → rsp_err=1; the next transfer shows rsp_err=0.
- Timeout: PREADY stuck 0, TIMEOUT=16 → abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, back in IDLE.
- Reset mid-ACCESS: assert PRESET during a wait state → all outputs 0 immediately, no rsp_valid, and requester 0 is granted first after release.
